// File: rtl/l2_cache_pkg.sv
// Shared types and defaults for the L2 tag fill writer and its replacement selector.
// Tree pseudo-LRU helpers are used only when PLRU_EN is defined.
package l2_cache_pkg;

    localparam int TAG_W_DEF  = 5;
    localparam int SET_W_DEF  = 4;
    localparam int WAYS_DEF   = 4;
    localparam int ADDR_W_DEF = TAG_W_DEF + SET_W_DEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VICTIM = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        WRITE  = 3'd4
    } fill_state_e;

    // bit0 picks the half (1 = upper), bit1/bit2 pick the way inside the lower/upper half.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        logic [1:0] way;
        if (bits[0]) begin
            way = {1'b1, bits[2]};
        end else begin
            way = {1'b0, bits[1]};
        end
        return way;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nxt;
        nxt    = bits;
        nxt[0] = ~way[1];
        if (way[1]) begin
            nxt[2] = ~way[0];
        end else begin
            nxt[1] = ~way[0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/l2_replacement_sel.sv
// Victim way selection: lowest invalid way first, otherwise the replacement policy.
// Policy is a per-set 3-bit tree PLRU when PLRU_EN is defined, else a global round-robin pointer.
module l2_replacement_sel
    import l2_cache_pkg::*;
#(
    parameter int SET_W = SET_W_DEF,
    parameter int WAYS  = WAYS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] q_set,
    input  logic [WAYS-1:0]  q_valid,
    output logic [1:0]       victim_way,
    input  logic             upd_en,
    input  logic [SET_W-1:0] upd_set,
    input  logic [1:0]       upd_way,
    input  logic             hit_en,
    input  logic [SET_W-1:0] hit_set,
    input  logic [1:0]       hit_way
);
    localparam int SETS = 1 << SET_W;

    logic       any_inv_s;
    logic [1:0] low_inv_s;
    logic [1:0] policy_s;

    // Scan downwards so the lowest invalid index is the one that sticks.
    always_comb begin
        any_inv_s = 1'b0;
        low_inv_s = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            any_inv_s = any_inv_s | ~q_valid[w];
            low_inv_s = q_valid[w] ? low_inv_s : 2'(w);
        end
    end

    assign victim_way = any_inv_s ? low_inv_s : policy_s;

`ifdef PLRU_EN
    logic [SETS-1:0][2:0] plru_q;
    logic [SETS-1:0][2:0] plru_d;
    logic                 hit_apply_s;

    // A fill update to the same set in the same cycle wins over a hit touch.
    assign hit_apply_s = hit_en & ~(upd_en & (hit_set == upd_set));

    // Next PLRU state for every set.
    always_comb begin
        plru_d = plru_q;
        for (int s = 0; s < SETS; s++) begin
            plru_d[s] = (upd_en && (upd_set == SET_W'(s))) ? plru_touch(plru_q[s], upd_way) :
                        (hit_apply_s && (hit_set == SET_W'(s))) ? plru_touch(plru_q[s], hit_way) :
                        plru_q[s];
        end
    end

    // PLRU state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plru_q <= {SETS{3'b000}};
        end else begin
            plru_q <= plru_d;
        end
    end

    assign policy_s = plru_victim(plru_q[q_set]);
`else
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic       unused_hit_s;

    assign rr_d         = upd_en ? (rr_q + 2'd1) : rr_q;
    assign unused_hit_s = ^{hit_en, hit_set, hit_way, upd_set, upd_way};

    // Round-robin pointer register, advanced once per install.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign policy_s = rr_q;
`endif

endmodule

// File: rtl/l2_tag_fill_writer.sv
// L2 miss handler: allocates a victim way, writes back a dirty victim, fills, then installs the tag.
// Optional feature macro: PLRU_EN (tree pseudo-LRU replacement instead of round-robin).
module l2_tag_fill_writer
    import l2_cache_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int SET_W = SET_W_DEF,
    parameter int WAYS  = WAYS_DEF
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   missValid,
    output logic                   missReady,
    input  logic [TAG_W-1:0]       missTag,
    input  logic [SET_W-1:0]       missSet,
    input  logic                   missWrite,
    input  logic                   hitValid,
    input  logic [SET_W-1:0]       hitSet,
    input  logic [1:0]             hitWay,
    output logic [SET_W-1:0]       tagRdSet,
    input  logic [WAYS*TAG_W-1:0]  tagRdData,
    output logic                   tagWrEn,
    output logic [SET_W-1:0]       tagWrSet,
    output logic [1:0]             tagWrWay,
    output logic [TAG_W-1:0]       tagWrData,
    output logic                   wbValid,
    input  logic                   wbAck,
    output logic [TAG_W+SET_W-1:0] wbAddr,
    output logic                   fillValid,
    input  logic                   fillAck,
    output logic [TAG_W+SET_W-1:0] fillAddr,
    output logic                   doneValid,
    output logic [1:0]             doneWay,
    output logic [(1<<SET_W)*WAYS-1:0] lineValid
);
    localparam int SETS   = 1 << SET_W;
    localparam int ADDR_W = TAG_W + SET_W;

    fill_state_e state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             wr_q, wr_d;
    logic [1:0]       way_q, way_d;
    logic [TAG_W-1:0] old_tag_q, old_tag_d;
    logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;

    logic                       ready_q, wb_valid_q, fill_valid_q, wr_en_q;
    logic [SET_W-1:0]           rd_set_q, rd_set_d;
    logic [ADDR_W-1:0]          wb_addr_q, wb_addr_d, fill_addr_q, fill_addr_d;
    logic [WAYS-1:0][TAG_W-1:0] rd_tags_s;
    logic [1:0]                 victim_s;
    logic                       upd_en_s;

    assign rd_tags_s = tagRdData;
    assign upd_en_s  = (state_q == WRITE);

    l2_replacement_sel #(
        .SET_W (SET_W),
        .WAYS  (WAYS)
    ) u_repl (
        .clk        (clock),
        .rst_n      (resetN),
        .q_set      (set_q),
        .q_valid    (valid_q[set_q]),
        .victim_way (victim_s),
        .upd_en     (upd_en_s),
        .upd_set    (set_q),
        .upd_way    (way_q),
        .hit_en     (hitValid),
        .hit_set    (hitSet),
        .hit_way    (hitWay)
    );

    // Next-state and line-state update logic.
    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        tag_d     = tag_q;
        wr_d      = wr_q;
        way_d     = way_q;
        old_tag_d = old_tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        case (state_q)
            IDLE: begin
                if (missValid) begin
                    set_d   = missSet;
                    tag_d   = missTag;
                    wr_d    = missWrite;
                    state_d = VICTIM;
                end else begin
                    state_d = IDLE;
                end
            end
            VICTIM: begin
                way_d     = victim_s;
                old_tag_d = rd_tags_s[victim_s];
                if (valid_q[set_q][victim_s] && dirty_q[set_q][victim_s]) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB: begin
                if (wbAck) begin
                    state_d = FILL;
                end else begin
                    state_d = WB;
                end
            end
            FILL: begin
                if (fillAck) begin
                    state_d = WRITE;
                end else begin
                    state_d = FILL;
                end
            end
            WRITE: begin
                valid_d[set_q][way_q] = 1'b1;
                dirty_d[set_q][way_q] = wr_q;
                state_d               = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        rd_set_d    = (state_d == VICTIM) ? set_d : {SET_W{1'b0}};
        wb_addr_d   = (state_d == WB) ? {old_tag_d, set_d} : {ADDR_W{1'b0}};
        fill_addr_d = (state_d == FILL) ? {tag_d, set_d} : {ADDR_W{1'b0}};
    end

    // State, line bits and output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            set_q        <= {SET_W{1'b0}};
            tag_q        <= {TAG_W{1'b0}};
            wr_q         <= 1'b0;
            way_q        <= 2'd0;
            old_tag_q    <= {TAG_W{1'b0}};
            valid_q      <= {(SETS*WAYS){1'b0}};
            dirty_q      <= {(SETS*WAYS){1'b0}};
            ready_q      <= 1'b1;
            wb_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_set_q     <= {SET_W{1'b0}};
            wb_addr_q    <= {ADDR_W{1'b0}};
            fill_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            tag_q        <= tag_d;
            wr_q         <= wr_d;
            way_q        <= way_d;
            old_tag_q    <= old_tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            ready_q      <= (state_d == IDLE);
            wb_valid_q   <= (state_d == WB);
            fill_valid_q <= (state_d == FILL);
            wr_en_q      <= (state_d == WRITE);
            rd_set_q     <= rd_set_d;
            wb_addr_q    <= wb_addr_d;
            fill_addr_q  <= fill_addr_d;
        end
    end

    assign missReady = ready_q;
    assign tagRdSet  = rd_set_q;
    assign wbValid   = wb_valid_q;
    assign wbAddr    = wb_addr_q;
    assign fillValid = fill_valid_q;
    assign fillAddr  = fill_addr_q;
    assign tagWrEn   = wr_en_q;
    assign doneValid = wr_en_q;
    assign tagWrSet  = wr_en_q ? set_q : {SET_W{1'b0}};
    assign tagWrWay  = wr_en_q ? way_q : 2'd0;
    assign tagWrData = wr_en_q ? tag_q : {TAG_W{1'b0}};
    assign doneWay   = wr_en_q ? way_q : 2'd0;
    assign lineValid = valid_q;

endmodule

// File: tb/tb_l2_tag_fill_writer.sv
// Directed bench for l2_tag_fill_writer with a per-set cache model and a per-cycle monitor.
module tb_l2_tag_fill_writer;
    localparam int TAG_W = 5;
    localparam int SET_W = 4;
    localparam int WAYS  = 4;
    localparam int SETS  = 16;

    logic clock = 1'b0;
    logic resetN;
    logic missValid, missReady, missWrite, hitValid;
    logic [TAG_W-1:0] missTag;
    logic [SET_W-1:0] missSet, hitSet, tagRdSet, tagWrSet;
    logic [1:0] hitWay, tagWrWay, doneWay;
    logic [WAYS*TAG_W-1:0] tagRdData;
    logic tagWrEn, wbValid, wbAck, fillValid, fillAck, doneValid;
    logic [TAG_W-1:0] tagWrData;
    logic [TAG_W+SET_W-1:0] wbAddr, fillAddr;
    logic [SETS*WAYS-1:0] lineValid;

    always #5 clock = ~clock;

    l2_tag_fill_writer dut (
        .clock(clock), .resetN(resetN),
        .missValid(missValid), .missReady(missReady), .missTag(missTag), .missSet(missSet),
        .missWrite(missWrite), .hitValid(hitValid), .hitSet(hitSet), .hitWay(hitWay),
        .tagRdSet(tagRdSet), .tagRdData(tagRdData), .tagWrEn(tagWrEn), .tagWrSet(tagWrSet),
        .tagWrWay(tagWrWay), .tagWrData(tagWrData), .wbValid(wbValid), .wbAck(wbAck),
        .wbAddr(wbAddr), .fillValid(fillValid), .fillAck(fillAck), .fillAddr(fillAddr),
        .doneValid(doneValid), .doneWay(doneWay), .lineValid(lineValid)
    );

    // External tag RAM: combinational read, write on the strobe.
    logic [TAG_W-1:0] tag_ram [SETS][WAYS];
    assign tagRdData = {tag_ram[tagRdSet][3], tag_ram[tagRdSet][2], tag_ram[tagRdSet][1], tag_ram[tagRdSet][0]};
    always @(posedge clock) if (tagWrEn) tag_ram[tagWrSet][tagWrWay] <= tagWrData;

    // Cache model: what each line holds and how the policy stands.
    logic [SETS-1:0][WAYS-1:0] m_valid;
    logic [SETS-1:0][WAYS-1:0] m_dirty;
    logic [TAG_W-1:0] m_tag [SETS][WAYS];
    int  m_rr;
    bit  m_upper [SETS];   // victim lies in ways 2..3
    bit  m_lo_one [SETS];  // inside ways 0..1, victim is way 1
    bit  m_hi_one [SETS];  // inside ways 2..3, victim is way 3
    bit  exp_wr;
    bit  run;

    int total = 0;
    int bad   = 0;
    int last_way, last_lat;
    logic [TAG_W+SET_W-1:0] last_wb_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = '0;
        m_dirty = '0;
        m_rr    = 0;
        for (int s = 0; s < SETS; s++) begin
            m_upper[s] = 0; m_lo_one[s] = 0; m_hi_one[s] = 0;
            for (int w = 0; w < WAYS; w++) m_tag[s][w] = '0;
        end
    endtask

    // Most-recent touch: every decision on the path points at the other side.
    task automatic model_touch(input int s, input int w);
        m_upper[s] = (w < 2);
        if (w < 2) m_lo_one[s] = (w == 0);
        else       m_hi_one[s] = (w == 2);
    endtask

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
`ifdef PLRU_EN
        if (m_upper[s]) return m_hi_one[s] ? 3 : 2;
        return m_lo_one[s] ? 1 : 0;
`else
        return m_rr;
`endif
    endfunction

    // Every cycle: valid bits track the model; install strobes appear only where expected.
    always @(negedge clock) begin
        if (run && resetN) begin
            chk("line_valid", lineValid, m_valid);
            chk("tag_wr_en", tagWrEn, exp_wr);
            chk("done_valid", doneValid, exp_wr);
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        resetN = 1'b0;
        #1;
        chk("rst_ready", missReady, 1);
        chk("rst_wr_en", tagWrEn, 0);
        chk("rst_done", doneValid, 0);
        chk("rst_wb", wbValid, 0);
        chk("rst_fill", fillValid, 0);
        chk("rst_line_valid", lineValid, 0);
        model_clear();
        exp_wr = 0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_miss(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set, input logic wr,
                           input int wb_wait, input int fill_wait, input logic ack_early);
        int v, lat;
        bit need_wb;
        logic [TAG_W-1:0] old;
        v       = model_victim(set);
        need_wb = m_valid[set][v] && m_dirty[set][v];
        old     = m_tag[set][v];
        chk("idle_ready", missReady, 1);
        missValid = 1; missTag = tag; missSet = set; missWrite = wr; fillAck = ack_early;
        @(negedge clock);
        lat = 1;
        missValid = 0; missWrite = 0;
        chk("victim_rd_set", tagRdSet, set);
        chk("victim_ready", missReady, 0);
        chk("victim_no_fill", fillValid, 0);
        chk("victim_no_wb", wbValid, 0);
        if (need_wb) begin
            for (int i = 0; i <= wb_wait; i++) begin
                @(negedge clock);
                lat++;
                chk("wb_valid", wbValid, 1);
                chk("wb_addr", wbAddr, {old, set});
                chk("wb_no_fill", fillValid, 0);
                last_wb_addr = wbAddr;
                wbAck = (i == wb_wait);
            end
        end
        for (int i = 0; i <= fill_wait; i++) begin
            @(negedge clock);
            lat++;
            wbAck = 0;
            chk("fill_valid", fillValid, 1);
            chk("fill_addr", fillAddr, {tag, set});
            chk("fill_no_wb", wbValid, 0);
            fillAck = (i == fill_wait);
        end
        @(posedge clock);
        #1 exp_wr = 1;
        @(negedge clock);
        lat++;
        fillAck = 0;
        chk("wr_set", tagWrSet, set);
        chk("wr_way", tagWrWay, v);
        chk("wr_data", tagWrData, tag);
        chk("done_way", doneWay, v);
        last_way = tagWrWay;
        last_lat = lat;
        @(posedge clock);
        exp_wr = 0;
        m_valid[set][v] = 1'b1;
        m_dirty[set][v] = wr;
        m_tag[set][v]   = tag;
        m_rr = (m_rr + 1) % 4;
        model_touch(set, v);
        @(negedge clock);
    endtask

    task automatic do_hit(input logic [SET_W-1:0] s, input logic [1:0] w);
        hitValid = 1; hitSet = s; hitWay = w;
        @(posedge clock);
`ifdef PLRU_EN
        model_touch(s, w);
`endif
        @(negedge clock);
        hitValid = 0;
    endtask

    initial begin
        resetN = 0; missValid = 0; missTag = 0; missSet = 0; missWrite = 0;
        hitValid = 0; hitSet = 0; hitWay = 0; wbAck = 0; fillAck = 0; exp_wr = 0; run = 0;
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) tag_ram[s][w] = '0;
        model_clear();
        apply_reset();
        run = 1;

        // Single read miss, minimum latency.
        do_miss(5'h0A, 4'd3, 1'b0, 0, 0, 1'b0);
        chk("a_way_literal", last_way, 0);
        chk("a_latency_literal", last_lat, 3);
        chk("a_line_literal", lineValid[12], 1);

        // Fill set 5, then a fifth miss.
        apply_reset();
        for (int t = 1; t <= 4; t++) begin
            do_miss(5'(t), 4'd5, 1'b0, 0, 0, 1'b0);
            chk("b_fill_order", last_way, t - 1);
        end
        do_miss(5'h06, 4'd5, 1'b0, 0, 1, 1'b0);
        chk("b_fifth_literal", last_way, 0);

        // Same, with a hit on way 0 before the fifth miss.
        apply_reset();
        for (int t = 1; t <= 4; t++) do_miss(5'(t), 4'd5, 1'b0, 0, 0, 1'b0);
        do_hit(4'd5, 2'd0);
        do_miss(5'h06, 4'd5, 1'b0, 0, 0, 1'b0);
`ifdef PLRU_EN
        chk("c_fifth_literal", last_way, 2);
`else
        chk("c_fifth_literal", last_way, 0);
`endif

        // Dirty victim writeback held for four cycles.
        apply_reset();
        do_miss(5'h11, 4'd2, 1'b1, 0, 0, 1'b0);
        do_miss(5'h12, 4'd2, 1'b0, 0, 0, 1'b0);
        do_miss(5'h13, 4'd2, 1'b0, 0, 2, 1'b0);
        do_miss(5'h14, 4'd2, 1'b0, 0, 0, 1'b0);
        last_wb_addr = '0;
        do_miss(5'h15, 4'd2, 1'b0, 3, 0, 1'b0);
        chk("d_wb_addr_literal", last_wb_addr, 9'h112);
        chk("d_way_literal", last_way, 0);
        chk("d_lat_literal", last_lat, 7);

        // Reset while in FILL abandons the install.
        missValid = 1; missTag = 5'h1F; missSet = 4'd7; missWrite = 0;
        @(negedge clock);
        missValid = 0;
        @(negedge clock);
        chk("e_in_fill", fillValid, 1);
        resetN = 0;
        #1;
        chk("e_rst_fill", fillValid, 0);
        chk("e_rst_ready", missReady, 1);
        chk("e_rst_lines", lineValid, 0);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("e_no_wr", tagWrEn, 0);
            chk("e_no_done", doneValid, 0);
        end
        resetN = 1;
        @(negedge clock);
        chk("e_ready_after", missReady, 1);
        chk("e_lines_after", lineValid, 0);

        // fillAck held high while idle is ignored.
        fillAck = 1;
        repeat (3) @(negedge clock);
        chk("f_idle_ready", missReady, 1);
        chk("f_idle_no_fill", fillValid, 0);
        do_miss(5'h07, 4'd9, 1'b0, 0, 0, 1'b1);
        chk("f_latency_literal", last_lat, 3);
        chk("f_way_literal", last_way, 0);

        repeat (2) @(negedge clock);
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule

// File: doc/l2_tag_fill_writer.md
Name: l2_tag_fill_writer

Overview:
- Write-side counterpart of the L2 tag comparator: on a lookup miss, allocates a way, writes back a dirty victim, requests the fill, then writes the new tag into the tag RAM.
- Owns per-line valid/dirty bits and replacement state; the tag RAM itself is external.
- Sits between the L2 lookup pipeline (miss source) and the memory-side request interface.

Parameters:
- TAG_W, 5, tag width in bits (matches the comparator).
- SET_W, 4, set index width; SETS = 2**SET_W.
- WAYS, 4, associativity; fixed at 4 when PLRU_EN is defined.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- missValid  in  1  miss request valid.
- missReady  out  1  block can accept a miss.
- missTag  in  TAG_W  tag of the missing address.
- missSet  in  SET_W  set of the missing address.
- missWrite  in  1  miss came from a write; the installed line is marked dirty.
- hitValid  in  1  hit touch, used for replacement update.
- hitSet  in  SET_W  set of the hit.
- hitWay  in  2  way of the hit.
- tagRdSet  out  SET_W  tag RAM read set index.
- tagRdData  in  WAYS*TAG_W  tags of tagRdSet, combinational return.
- tagWrEn  out  1  tag RAM write strobe.
- tagWrSet  out  SET_W  write set index.
- tagWrWay  out  2  write way index.
- tagWrData  out  TAG_W  tag value to write.
- wbValid  out  1  writeback request.
- wbAck  in  1  writeback accepted.
- wbAddr  out  TAG_W+SET_W  victim address, {oldTag, set}.
- fillValid  out  1  fill request.
- fillAck  in  1  fill data delivered.
- fillAddr  out  TAG_W+SET_W  address {missTag, missSet}.
- doneValid  out  1  one-cycle pulse when the install completes.
- doneWay  out  2  way installed.
- lineValid  out  SETS*WAYS  valid bits, flat, for the comparator.

Behaviour:
- Reset (asynchronous, resetN=0): state IDLE, all valid/dirty/replacement bits 0, missReady=1, all other outputs 0.
- IDLE: missReady=1. On missValid, latch tag, set and write flag, then go to VICTIM. missReady=0 in every other state.
- VICTIM (1 cycle): tagRdSet = latched set.
  - Victim is the lowest-index invalid way if any way is invalid; otherwise the replacement policy chooses.
  - If the victim is valid and dirty: latch the old tag, go to WB. Otherwise go to FILL.
- WB: hold wbValid=1 and wbAddr stable until the cycle wbAck=1, then go to FILL.
- FILL: hold fillValid=1 and fillAddr until fillAck=1, then go to WRITE.
- WRITE (1 cycle):
  - tagWrEn=1 with set, way and missTag on the write outputs.
  - valid[set][way]=1; dirty[set][way]=missWrite.
  - Update replacement state to mark the way most-recent.
  - doneValid=1 with doneWay; then go to IDLE.
- Minimum latency, miss accept to doneValid: 3 cycles (VICTIM, FILL with same-cycle ack, WRITE).
- An ack received outside its own state is ignored.
- Hit touch: applied on any cycle hitValid=1.
  - If it targets the same set as a WRITE-cycle update in that cycle, the fill update wins and the hit is dropped.
  - Hits to other sets are applied in the same cycle.
- Reset mid-operation: the transaction is abandoned immediately; no tagWrEn or doneValid is produced.

Optional Feature:
- Macro PLRU_EN.
- Defined: 3-bit tree pseudo-LRU per set.
  - Bit0 selects the half; bit1 or bit2 selects the way within it.
  - On an update, each bit on the path is set to point away from the touched way.
- Undefined: one global 2-bit round-robin pointer, incremented modulo 4 on each WRITE. hitValid is ignored.

Decomposition:
- Shared package l2_cache_pkg:
  - TAG_W, SET_W and WAYS defaults.
  - FSM state enum: IDLE, VICTIM, WB, FILL, WRITE.
  - Address concatenation width constant.
- One sub-module: l2_replacement_sel. It holds the PLRU array or round-robin pointer and outputs the victim way given the set and the valid vector.

Test Plan:
- Reset, then miss tag=0x0A set=3 read, fillAck on the first FILL cycle -> tagWrEn at cycle 3 with way0, tag 0x0A; doneWay=0; lineValid bit set 3, way 0 = 1; no wbValid.
- Four misses to set 5 with tags 1..4, then a fifth miss, PLRU_EN defined -> ways 0..3 filled in order; fifth victim is way0.
- As above, plus hit touch set=5 way=0 before the fifth miss -> fifth victim is way2.
- Write miss fills set 2 way0 dirty, set 2 is made full, way0 is then chosen as victim -> wbValid with wbAddr={old tag, 2}; held 4 cycles until wbAck; fillValid follows in the next cycle.
- Assert resetN=0 while in FILL -> no tagWrEn and no doneValid; after release, missReady=1 and lineValid=0.
- fillAck held high while IDLE, then a miss is accepted -> ack ignored in IDLE; the install still follows the VICTIM, FILL, WRITE sequence.
